// File: rtl/fifo_share_ctrl_if.sv
// Bundle of requester, FIFO-port and consumer signals around fifo_share_ctrl.
// master is the controller's view; slave is the surrounding requesters/FIFO/consumer.
interface fifo_share_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = 64
);
  localparam int IW = $clog2(N);
  localparam int FW = DW + IW;

  logic          arb_en;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;

  logic          fifo_wr_en;
  logic [FW-1:0] fifo_din;
  logic          fifo_full;
  logic          fifo_rd_en;
  logic [FW-1:0] fifo_dout;
  logic          fifo_empty;

  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  logic          out_ready;

  modport master (
    input  arb_en, in_valid, in_data, fifo_full, fifo_dout, fifo_empty, out_ready,
    output in_ready, fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data, out_id
  );

  modport slave (
    output arb_en, in_valid, in_data, fifo_full, fifo_dout, fifo_empty, out_ready,
    input  in_ready, fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data, out_id
  );
endinterface

// File: rtl/fifo_share_ctrl.sv
// Round-robin sharing of one synchronous FIFO among N writers, with a read
// sequencer that hides the FIFO read latency behind a 2-entry valid/ready buffer.
//
// state     | meaning
// BUF_EMPTY | no word buffered, out_valid low
// BUF_ONE   | one word buffered, head presented on out_*
// BUF_TWO   | buffer full, reads issued only when a pop frees a slot
module fifo_share_ctrl #(
  parameter int N  = 4,
  parameter int DW = 64
) (
  input  logic clk,
  input  logic nreset,
  fifo_share_ctrl_if.master bus
);
  localparam int IW = $clog2(N);
  localparam int FW = DW + IW;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  // ---------------- write arbitration ----------------
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic          found;
  logic          grant;
  logic [N-1:0]  ready;
  logic [DW-1:0] sel_data;
  int            idx;

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!found && bus.in_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Reset gates the grant so in_ready/fifo_wr_en fall the moment nreset drops.
  assign grant = nreset & bus.arb_en & ~bus.fifo_full & found;

  always_comb begin
    ready    = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IW'(i)) begin
        ready[i] = grant;
        sel_data = bus.in_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr <= IW'(N - 1);
    end else if (grant) begin
      ptr <= winner;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.fifo_wr_en = grant;
  assign bus.fifo_din   = grant ? {winner, sel_data} : '0;

  // ---------------- read sequencing ----------------
  buf_state_t    state;
  buf_state_t    state_nxt;
  logic [1:0]    count;
  logic [1:0]    occ;
  logic          inflight;
  logic          push;
  logic          pop;
  logic          rd_en;
  logic          out_valid;
  logic [FW-1:0] mem [2];
  logic          head;
  logic          tail;

  assign count     = state;
  assign out_valid = (state != BUF_EMPTY);
  assign pop       = out_valid & bus.out_ready;
  assign push      = inflight;
  assign occ       = count + {1'b0, inflight};

  // A read may be launched into a slot that this cycle's pop is freeing.
  assign rd_en = nreset & ~bus.fifo_empty &
                 ({1'b0, occ} < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY: if (push) state_nxt = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_nxt = BUF_TWO;
        else if (!push && pop) state_nxt = BUF_EMPTY;
      end
      BUF_TWO: if (pop && !push) state_nxt = BUF_ONE;
      default: state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= rd_en;
      if (push) begin
        mem[tail] <= bus.fifo_dout;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = mem[head][DW-1:0];
  assign bus.out_id     = mem[head][FW-1:DW];

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Directed and randomized bench for fifo_share_ctrl with a behavioural FIFO and
// queue-based reference model of arbitration and output buffering.
module tb_fifo_share_ctrl;
  localparam int N      = 4;
  localparam int DW     = 64;
  localparam int IW     = $clog2(N);
  localparam int FW     = DW + IW;
  localparam int FDEPTH = 4;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  fifo_share_ctrl_if #(.N(N), .DW(DW)) bus ();

  fifo_share_ctrl #(.N(N), .DW(DW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  // behavioural FIFO
  logic [FW-1:0] fq[$];
  int            fcount;
  logic [FW-1:0] fdout;
  logic          force_full;

  assign bus.fifo_full  = (fcount == FDEPTH) || force_full;
  assign bus.fifo_empty = (fcount == 0);
  assign bus.fifo_dout  = fdout;

  // reference model
  int            m_ptr;
  logic [FW-1:0] m_buf[$];
  bit            m_infl;
  logic [FW-1:0] m_infl_word;
  int            n_grant;
  int            n_seen;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    fq.delete();
    fcount      = 0;
    fdout       = '0;
    m_buf.delete();
    m_infl      = 0;
    m_infl_word = '0;
    m_ptr       = N - 1;
    n_grant     = 0;
    n_seen      = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = {$urandom(), $urandom()};
  endtask

  // Called at posedge+1 with inputs applied; checks the cycle and advances one edge.
  task automatic cycle();
    int            w;
    int            occ;
    bit            g, pop, exp_rd, exp_ov, rd_act, wr_act;
    logic [N-1:0]  exp_rdy;
    logic [IW-1:0] wid;
    logic [FW-1:0] din_act;
    #1;
    w       = rr_pick(m_ptr, bus.in_valid);
    g       = bus.arb_en && !bus.fifo_full && (w >= 0);
    exp_rdy = '0;
    wid     = '0;
    if (g) begin
      exp_rdy[w] = 1'b1;
      wid        = IW'(w);
    end
    check("in_ready", bus.in_ready, exp_rdy);
    check("fifo_wr_en", bus.fifo_wr_en, g);
    if (g) check("fifo_din", bus.fifo_din, {wid, bus.in_data[w*DW +: DW]});
    exp_ov = (m_buf.size() != 0);
    pop    = exp_ov && bus.out_ready;
    occ    = m_buf.size() + (m_infl ? 1 : 0);
    exp_rd = (fcount != 0) && (occ < 2 + (pop ? 1 : 0));
    check("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) begin
      check("out_data", bus.out_data, m_buf[0][DW-1:0]);
      check("out_id", bus.out_id, m_buf[0][FW-1:DW]);
    end
    check("fifo_rd_en", bus.fifo_rd_en, exp_rd);
    if (bus.out_valid && bus.out_ready) n_seen++;
    rd_act  = bus.fifo_rd_en;
    wr_act  = bus.fifo_wr_en;
    din_act = bus.fifo_din;
    @(posedge clk);
    #1;
    if (pop) void'(m_buf.pop_front());
    if (m_infl) m_buf.push_back(m_infl_word);
    m_infl = exp_rd;
    if (rd_act && fq.size() != 0) fdout = fq.pop_front();
    if (wr_act && fq.size() < FDEPTH) fq.push_back(din_act);
    fcount      = fq.size();
    m_infl_word = fdout;
    if (g) begin
      m_ptr = w;
      n_grant++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    nreset         = 1'b0;
    force_full     = 1'b0;
    bus.arb_en     = 1'b1;
    bus.in_valid   = '1;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    model_reset();

    // reset state, with all requesters asserting
    #2;
    check("rst_in_ready", bus.in_ready, '0);
    check("rst_wr_en", bus.fifo_wr_en, 1'b0);
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_id", bus.out_id, '0);
    @(posedge clk); #1;
    bus.in_valid = '0;
    nreset = 1'b1;

    // single word: latency T -> out_valid at T+3
    bus.in_valid = 4'b0001;
    bus.in_data[0 +: DW] = 64'hA5;
    cycle();
    bus.in_valid = '0;
    cycle();
    cycle();
    #1;
    check("single_valid_t3", bus.out_valid, 1'b1);
    check("single_data", bus.out_data, 64'hA5);
    check("single_id", bus.out_id, 0);
    for (int i = 0; i < 5; i++) cycle();
    check("single_count", n_seen, 1);

    // all requesters busy
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 16; i++) begin rand_data(); cycle(); end

    // sparse requesters 1 and 3
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 10; i++) begin rand_data(); cycle(); end

    // forced full: no grants, pointer frozen, resumes at ptr+1
    bus.in_valid = 4'b1111;
    force_full   = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_data(); cycle(); end
    force_full = 1'b0;
    for (int i = 0; i < 6; i++) begin rand_data(); cycle(); end

    // output backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) bus.in_valid = '0;
      rand_data();
      cycle();
    end
    #1;
    check("bp_out_valid", bus.out_valid, 1'b1);
    check("bp_rd_held", bus.fifo_rd_en, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = N'($urandom());
      bus.arb_en    = ($urandom_range(0, 7) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      force_full    = ($urandom_range(0, 9) == 0);
      rand_data();
      cycle();
    end
    force_full    = 1'b0;
    bus.arb_en    = 1'b1;
    bus.out_ready = 1'b1;

    // reset mid-operation with words buffered and a read in flight
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin rand_data(); cycle(); end
    #1;
    check("pre_rst_out_valid", bus.out_valid, 1'b1);
    nreset = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, '0);
    check("mid_rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("mid_rst_wr_en", bus.fifo_wr_en, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    nreset = 1'b1;
    #1;
    check("post_rst_first_grant", bus.in_ready, 4'b0001);
    for (int i = 0; i < 6; i++) begin rand_data(); cycle(); end

    // drain and confirm every granted word came out exactly once
    bus.in_valid = '0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      done = (fcount == 0) && (m_buf.size() == 0) && !m_infl;
    end
    check("drain_done", done, 1'b1);
    check("drain_count", n_seen, n_grant);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
